// File: rtl/cipher_sequencer.sv
// Sequencer for a serial XOR cipher: loads a key word and a data word through
// external deserializers, XORs them, and streams the result out MSB first.
module cipher_sequencer #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic                 iAbort,
  input  logic                 iSerial_valid,
  input  logic [DATA_SIZE-1:0] iKey_word,
  input  logic [DATA_SIZE-1:0] iData_word,
  input  logic                 iOut_ready,
  output logic                 oKey_en,
  output logic                 oData_en,
  output logic                 oLoading,
  output logic                 oSerial_out,
  output logic                 oOut_valid,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2:0]           oState
);

  localparam int CW = $clog2(DATA_SIZE) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_KEY  = 3'd1,
    LOAD_DATA = 3'd2,
    XOR       = 3'd3,
    SHIFT_OUT = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CW-1:0]        r_cnt;
  logic [DATA_SIZE-1:0] r_result;
  logic                 w_cnt_inc;
  logic                 w_shift;

  always_comb begin
    w_state_next = r_state;
    w_cnt_inc    = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: if (iStart) w_state_next = LOAD_KEY;
      LOAD_KEY: if (iSerial_valid) begin
        w_cnt_inc = 1'b1;
        if (r_cnt == LAST) w_state_next = LOAD_DATA;
      end
      LOAD_DATA: if (iSerial_valid) begin
        w_cnt_inc = 1'b1;
        if (r_cnt == LAST) w_state_next = XOR;
      end
      XOR: w_state_next = SHIFT_OUT;
      SHIFT_OUT: if (iOut_ready) begin
        w_cnt_inc = 1'b1;
        w_shift   = 1'b1;
        if (r_cnt == LAST) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // Abort overrides everything, including the final bit of a phase.
    if (iAbort && (r_state != IDLE)) begin
      w_state_next = IDLE;
      w_cnt_inc    = 1'b0;
      w_shift      = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      // The counter restarts on every state entry.
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == XOR) begin
        r_result <= iKey_word ^ iData_word;
      end else if (w_shift) begin
        r_result <= {r_result[DATA_SIZE-2:0], 1'b0};
      end
    end
  end

  // Enables are gated by reset and abort so no deserializer shifts in those cycles.
  assign oKey_en     = iRst && !iAbort && iSerial_valid && (r_state == LOAD_KEY);
  assign oData_en    = iRst && !iAbort && iSerial_valid && (r_state == LOAD_DATA);
  assign oLoading    = (r_state == LOAD_KEY) || (r_state == LOAD_DATA);
  assign oOut_valid  = (r_state == SHIFT_OUT);
  assign oSerial_out = (r_state == SHIFT_OUT) && r_result[DATA_SIZE-1];
  assign oBusy       = (r_state != IDLE);
  assign oDone       = (r_state == DONE);
  assign oState      = r_state;

endmodule

// File: tb/tb_cipher_sequencer.sv
// Scoreboard bench for cipher_sequencer (DATA_SIZE=8) with behavioural
// key/data deserializers driven by the DUT shift enables.
module tb_cipher_sequencer;

  localparam int DW = 8;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart;
  logic          iAbort;
  logic          iSerial_valid;
  logic          serial_bit;
  logic [DW-1:0] key_sr;
  logic [DW-1:0] data_sr;
  logic          iOut_ready;
  logic          oKey_en, oData_en, oLoading, oSerial_out, oOut_valid, oBusy, oDone;
  logic [2:0]    oState;

  int n_total = 0;
  int n_pass  = 0;
  int key_en_cnt, data_en_cnt, done_cnt, valid_cnt;
  logic exp_q[$];

  always #5 iClk = ~iClk;

  cipher_sequencer #(.DATA_SIZE(DW)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iAbort(iAbort),
    .iSerial_valid(iSerial_valid), .iKey_word(key_sr), .iData_word(data_sr),
    .iOut_ready(iOut_ready), .oKey_en(oKey_en), .oData_en(oData_en),
    .oLoading(oLoading), .oSerial_out(oSerial_out), .oOut_valid(oOut_valid),
    .oBusy(oBusy), .oDone(oDone), .oState(oState)
  );

  // External deserializers: MSB-first shift-in.
  always @(posedge iClk) begin
    if (oKey_en)  key_sr  <= {key_sr[DW-2:0], serial_bit};
    if (oData_en) data_sr <= {data_sr[DW-2:0], serial_bit};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every accepted output bit is compared against the scoreboard.
  always @(negedge iClk) begin
    if (oKey_en)    key_en_cnt++;
    if (oData_en)   data_en_cnt++;
    if (oDone)      done_cnt++;
    if (oOut_valid) valid_cnt++;
    if (oOut_valid && iOut_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_bit", {31'd0, oSerial_out}, 32'hDEAD);
      end else begin
        logic e;
        e = exp_q.pop_front();
        check("out_bit", {31'd0, oSerial_out}, {31'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic clear_counts();
    key_en_cnt = 0; data_en_cnt = 0; done_cnt = 0; valid_cnt = 0;
  endtask

  // Sends one word MSB first; optional idle gap before each bit and an
  // iStart pulse on bit 3 to check that it is ignored.
  task automatic send_word(input logic [DW-1:0] w, input bit gaps, input bit start_pulse);
    for (int i = DW - 1; i >= 0; i--) begin
      if (gaps) begin
        iSerial_valid = 1'b0;
        tick();
      end
      serial_bit    = w[i];
      iSerial_valid = 1'b1;
      iStart        = start_pulse && (i == 3);
      tick();
    end
    iSerial_valid = 1'b0;
    iStart        = 1'b0;
  endtask

  task automatic run_txn(input string name, input logic [DW-1:0] k, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp_res, input bit gaps, input bit bp, input bit sb);
    logic hold_bit;
    bit   reached;
    clear_counts();
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(exp_res[i]);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check({name, "_state_load_key"}, {29'd0, oState}, 32'd1);
    check({name, "_loading"}, {31'd0, oLoading}, 32'd1);
    send_word(k, gaps, sb);
    check({name, "_state_load_data"}, {29'd0, oState}, 32'd2);
    send_word(d, gaps, 1'b0);
    check({name, "_valid_lat1"}, {31'd0, oOut_valid}, 32'd0);
    tick();
    check({name, "_valid_lat2"}, {31'd0, oOut_valid}, 32'd1);
    if (bp) begin
      repeat (3) tick();
      iOut_ready = 1'b0;
      hold_bit = oSerial_out;
      for (int c = 0; c < 3; c++) begin
        tick();
        check({name, "_bp_valid_hold"}, {31'd0, oOut_valid}, 32'd1);
        check({name, "_bp_bit_hold"}, {31'd0, oSerial_out}, {31'd0, hold_bit});
      end
      iOut_ready = 1'b1;
    end
    reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      if (oState == 3'd5) reached = 1'b1;
      else tick();
    end
    check({name, "_reached_done"}, {31'd0, reached}, 32'd1);
    iStart = sb;
    tick();
    iStart = 1'b0;
    check({name, "_idle_after_done"}, {29'd0, oState}, 32'd0);
    tick();
    check({name, "_still_idle"}, {30'd0, oBusy, oOut_valid}, 32'd0);
    check({name, "_done_pulses"}, done_cnt, 32'd1);
    check({name, "_key_en_pulses"}, key_en_cnt, DW);
    check({name, "_data_en_pulses"}, data_en_cnt, DW);
    check({name, "_queue_drained"}, exp_q.size(), 32'd0);
    $display("txn %s key=%02h data=%02h expected=%02h", name, k, d, exp_res);
  endtask

  initial begin
    iRst = 1'b0; iStart = 1'b0; iAbort = 1'b0; iSerial_valid = 1'b0;
    serial_bit = 1'b0; iOut_ready = 1'b1; key_sr = '0; data_sr = '0;
    clear_counts();
    repeat (3) tick();
    check("reset_outputs", {oKey_en, oData_en, oLoading, oSerial_out, oOut_valid, oBusy, oDone, oState}, 32'd0);
    iRst = 1'b1;
    tick();
    check("idle_after_reset", {29'd0, oState}, 32'd0);

    run_txn("basic", 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0, 1'b0);
    run_txn("gaps",  8'hA5, 8'h3C, 8'h99, 1'b1, 1'b0, 1'b0);
    run_txn("backpressure", 8'h12, 8'h34, 8'h26, 1'b0, 1'b1, 1'b0);

    // Abort on the 5th data bit.
    clear_counts();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    send_word(8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      serial_bit = 1'b1; iSerial_valid = 1'b1;
      tick();
    end
    iAbort = 1'b1; serial_bit = 1'b1; iSerial_valid = 1'b1;
    @(negedge iClk);
    check("abort_data_en_low", {31'd0, oData_en}, 32'd0);
    tick();
    iAbort = 1'b0; iSerial_valid = 1'b0;
    check("abort_state_idle", {29'd0, oState}, 32'd0);
    check("abort_busy_low", {31'd0, oBusy}, 32'd0);
    repeat (12) tick();
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_no_valid", valid_cnt, 32'd0);
    check("abort_data_en_pulses", data_en_cnt, 32'd4);
    $display("txn abort after 4 data bits");
    run_txn("after_abort", 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);

    // Reset while the output stage is holding its first bit.
    clear_counts();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    send_word(8'hA5, 1'b0, 1'b0);
    send_word(8'h00, 1'b0, 1'b0);
    iOut_ready = 1'b0;
    tick();
    check("rst_pre_valid", {30'd0, oOut_valid, oSerial_out}, 32'd3);
    #2;
    iRst = 1'b0;
    iSerial_valid = 1'b1;
    #1;
    check("rst_async_outputs", {oKey_en, oData_en, oLoading, oSerial_out, oOut_valid, oBusy, oDone, oState}, 32'd0);
    tick();
    check("rst_held_outputs", {oKey_en, oData_en, oLoading, oSerial_out, oOut_valid, oBusy, oDone, oState}, 32'd0);
    iRst = 1'b1;
    iSerial_valid = 1'b0;
    iOut_ready = 1'b1;
    repeat (3) tick();
    check("rst_release_idle", {28'd0, oBusy, oState}, 32'd0);
    $display("txn reset during shift-out");

    run_txn("start_while_busy", 8'h3C, 8'h5A, 8'h66, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
